// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue port bundle: push side from inst SRAM return, issue side to decode.
// Latency: n/a (wires only).
// Backpressure: carried by afull/count toward IF; the consumer throttles via pop_cnt.
interface inst_fetch_queue_if #(
  parameter int DEPTH   = 8,
  parameter int ISSUE_W = 2
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(ISSUE_W + 1);

  logic                   flush;
  logic                   in_valid;
  logic [31:0]            in_pc;
  logic [31:0]            in_inst;
  logic [PW-1:0]          pop_cnt;
  logic [ISSUE_W-1:0]     out_valid;
  logic [32*ISSUE_W-1:0]  out_pc;
  logic [32*ISSUE_W-1:0]  out_inst;
  logic                   afull;
  logic [CW-1:0]          count;
  logic                   err_overflow;

  // fetch/issue side that drives pushes, pops and redirects
  modport master (
    output flush, in_valid, in_pc, in_inst, pop_cnt,
    input  out_valid, out_pc, out_inst, afull, count, err_overflow
  );

  // the queue itself
  modport slave (
    input  flush, in_valid, in_pc, in_inst, pop_cnt,
    output out_valid, out_pc, out_inst, afull, count, err_overflow
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular instruction buffer between inst SRAM return and issue; shows up to ISSUE_W oldest entries.
// Latency: push visible 1 cycle later (no bypass); flush empties the queue at the next edge.
// Backpressure: afull when free entries <= AFULL_MARGIN; a push at full is dropped and latches err_overflow.
module inst_fetch_queue #(
  parameter int DEPTH        = 8,
  parameter int ISSUE_W      = 2,
  parameter int AFULL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              resetn,
  inst_fetch_queue_if.slave fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]        mem_pc   [DEPTH];
  logic [31:0]        mem_inst [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [CW-1:0]      count_r;
  logic               err_r;
  logic [CW-1:0]      pop_eff;
  logic               room;
  logic               push;
  logic               drop;
  logic [ISSUE_W-1:0] slot_vld;

  // clamp the requested pop to what is present and to the slot count
  always_comb begin
    pop_eff = CW'(fq.pop_cnt);
    if (pop_eff > count_r) pop_eff = count_r;
    if (pop_eff > CW'(ISSUE_W)) pop_eff = CW'(ISSUE_W);
  end

  // a same-cycle pop frees space before the push is judged; flush suppresses both push and drop
  assign room = (count_r - pop_eff) < CW'(DEPTH);
  assign push = fq.in_valid && !fq.flush && room;
  assign drop = fq.in_valid && !fq.flush && !room;

  // pointer/occupancy state; flush wins over push and pop but leaves the sticky error alone
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_r <= '0;
      err_r   <= 1'b0;
    end else if (fq.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_r <= '0;
    end else begin
      rd_ptr  <= rd_ptr + AW'(pop_eff);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count_r <= count_r - pop_eff + CW'(push);
      if (drop) err_r <= 1'b1;
    end
  end

  // entry storage is write-only on accepted pushes and needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= fq.in_pc;
      mem_inst[wr_ptr] <= fq.in_inst;
    end
  end

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
    logic [AW-1:0] idx;
    assign idx         = rd_ptr + AW'(i);
    assign slot_vld[i] = count_r > CW'(i);
    // empty slots read as zero so stale storage never leaks downstream
    assign fq.out_pc[32*i +: 32]   = slot_vld[i] ? mem_pc[idx]   : 32'h0;
    assign fq.out_inst[32*i +: 32] = slot_vld[i] ? mem_inst[idx] : 32'h0;
  end

  assign fq.out_valid    = slot_vld;
  assign fq.count        = count_r;
  assign fq.err_overflow = err_r;
  assign fq.afull        = (CW'(DEPTH) - count_r) <= CW'(AFULL_MARGIN);
endmodule
